// File: rtl/parity_stream.sv
// Streaming parity engine: serially counts set bits of each accepted word, reports
// per-word and per-frame ones/parity. Optional 'E'/'O' HEX digit under PARITY_SEG_EN.
module parity_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(WIDTH+1)-1:0]   out_ones,
  output logic                         out_odd,
  output logic [CNT_W-1:0]             out_frame_ones,
  output logic                         out_frame_odd,
  output logic                         out_last
`ifdef PARITY_SEG_EN
  ,
  output logic [6:0]                   hex
`endif
);

  localparam int OW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   shreg;
  logic [OW-1:0]      word_cnt;
  logic [OW-1:0]      bit_idx;
  logic [OW-1:0]      word_total;
  logic [CNT_W:0]     frame_sum;
  logic [CNT_W-1:0]   frame_ones_next;
  logic               frame_odd_next;
  logic               accept;
  logic               scan_done;
  logic               out_hs;

  assign accept     = (state == IDLE) && in_valid && in_ready;
  assign scan_done  = (state == SCAN) && (bit_idx == OW'(WIDTH - 1));
  assign out_hs     = (state == HOLD) && out_ready;
  // Count including the bit being scanned this cycle.
  assign word_total = word_cnt + OW'(shreg[0]);
  assign frame_sum  = {1'b0, out_frame_ones} + (CNT_W+1)'(word_total);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every signal gets a default first, so no path through the block infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)    state_next = SCAN;
      SCAN:    if (scan_done) state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Frame parity follows the true (unsaturated) sum, so it toggles on odd word counts.
  always_comb begin
    frame_ones_next = out_frame_ones;
    frame_odd_next  = out_frame_odd;
    if (scan_done) begin
      frame_ones_next = frame_sum[CNT_W] ? '1 : frame_sum[CNT_W-1:0];
      frame_odd_next  = out_frame_odd ^ word_total[0];
    end else if (out_hs && out_last) begin
      frame_ones_next = '0;
      frame_odd_next  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready       <= 1'b0;
      out_valid      <= 1'b0;
      shreg          <= '0;
      word_cnt       <= '0;
      bit_idx        <= '0;
      out_ones       <= '0;
      out_odd        <= 1'b0;
      out_frame_ones <= '0;
      out_frame_odd  <= 1'b0;
      out_last       <= 1'b0;
    end else begin
      in_ready       <= (state_next == IDLE);
      out_valid      <= (state_next == HOLD);
      out_frame_ones <= frame_ones_next;
      out_frame_odd  <= frame_odd_next;
      if (accept) begin
        shreg    <= in_data;
        word_cnt <= '0;
        bit_idx  <= '0;
        out_last <= in_last;
      end else if (state == SCAN) begin
        shreg    <= shreg >> 1;
        word_cnt <= word_total;
        bit_idx  <= bit_idx + OW'(1);
      end
      if (scan_done) begin
        out_ones <= word_total;
        out_odd  <= word_total[0];
      end
    end
  end

`ifdef PARITY_SEG_EN
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_O = 7'b1000000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hex <= SEG_E;
    else        hex <= frame_odd_next ? SEG_O : SEG_E;
  end
`endif

endmodule

// File: tb/tb_parity_stream.sv
// Bench for parity_stream: scoreboard model checked every HOLD cycle on the main
// instance, plus directed checks on WIDTH=5 and CNT_W=4 instances.
module tb_parity_stream;

  localparam int     W   = 8;
  localparam int     CW  = 16;
  localparam longint SAT = (64'd1 << CW) - 1;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_O = 7'b1000000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // main instance (WIDTH=8, CNT_W=16)
  logic        in_valid, in_ready, in_last, out_valid, out_ready, out_odd, out_frame_odd, out_last;
  logic [7:0]  in_data;
  logic [3:0]  out_ones;
  logic [15:0] out_frame_ones;
  logic [6:0]  hex;

  // WIDTH=5 instance
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_odd, a_out_frame_odd, a_out_last;
  logic [4:0]  a_in_data;
  logic [2:0]  a_out_ones;
  logic [15:0] a_out_frame_ones;
  logic [6:0]  a_hex;

  // CNT_W=4 instance
  logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_odd, b_out_frame_odd, b_out_last;
  logic [7:0]  b_in_data;
  logic [3:0]  b_out_ones;
  logic [3:0]  b_out_frame_ones;
  logic [6:0]  b_hex;

  parity_stream #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_ones(out_ones),
    .out_odd(out_odd), .out_frame_ones(out_frame_ones), .out_frame_odd(out_frame_odd),
    .out_last(out_last)
`ifdef PARITY_SEG_EN
    , .hex(hex)
`endif
  );

  parity_stream #(.WIDTH(5), .CNT_W(16)) dut_w5 (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_last(1'b1), .out_valid(a_out_valid), .out_ready(1'b1), .out_ones(a_out_ones),
    .out_odd(a_out_odd), .out_frame_ones(a_out_frame_ones), .out_frame_odd(a_out_frame_odd),
    .out_last(a_out_last)
`ifdef PARITY_SEG_EN
    , .hex(a_hex)
`endif
  );

  parity_stream #(.WIDTH(8), .CNT_W(4)) dut_c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_last(b_in_last), .out_valid(b_out_valid), .out_ready(1'b1), .out_ones(b_out_ones),
    .out_odd(b_out_odd), .out_frame_ones(b_out_frame_ones), .out_frame_odd(b_out_frame_odd),
    .out_last(b_out_last)
`ifdef PARITY_SEG_EN
    , .hex(b_hex)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard model ----------------
  typedef struct {
    int     ones;
    bit     odd;
    longint frame;
    bit     fodd;
    bit     last;
    longint acc;
  } exp_t;

  exp_t   sb[$];
  longint true_sum   = 0;
  longint cyc        = 0;
  int     acc_count  = 0;
  bit     front_seen = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb.delete();
      true_sum   = 0;
      front_seen = 0;
    end else begin
      exp_t e;
      cyc++;
      if (out_valid && out_ready && sb.size() > 0) begin
        if (sb[0].last) true_sum = 0;
        void'(sb.pop_front());
        front_seen = 0;
      end
      if (in_valid && in_ready) begin
        e.ones   = $countones(in_data);
        true_sum = true_sum + e.ones;
        e.odd    = e.ones[0];
        e.frame  = (true_sum > SAT) ? SAT : true_sum;
        e.fodd   = true_sum[0];
        e.last   = in_last;
        e.acc    = cyc;
        sb.push_back(e);
        acc_count++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", 1, 0);
      end else begin
        check("sb_ones",       out_ones,       sb[0].ones);
        check("sb_odd",        out_odd,        sb[0].odd);
        check("sb_frame_ones", out_frame_ones, sb[0].frame);
        check("sb_frame_odd",  out_frame_odd,  sb[0].fodd);
        check("sb_last",       out_last,       sb[0].last);
`ifdef PARITY_SEG_EN
        check("sb_hex",        hex,            sb[0].fodd ? SEG_O : SEG_E);
`endif
        if (!front_seen) begin
          check("sb_latency", cyc - sb[0].acc, W);
          front_seen = 1;
        end
      end
      check("sb_in_ready_low", in_ready, 0);
    end
  end

  // ---------------- main-instance stimulus ----------------
  int n_sent = 0;

  task automatic send(input logic [7:0] d, input logic l);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("send_timeout", 0, 1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    n_sent++;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) check("valid_timeout", 0, 1);
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic expect_word(input string pre, input int ones, input int odd,
                             input int fones, input int fodd);
    wait_valid();
    check({pre, "_ones"},       out_ones,       ones);
    check({pre, "_odd"},        out_odd,        odd);
    check({pre, "_frame_ones"}, out_frame_ones, fones);
    check({pre, "_frame_odd"},  out_frame_odd,  fodd);
`ifdef PARITY_SEG_EN
    check({pre, "_hex"},        hex,            (fodd != 0) ? SEG_O : SEG_E);
`endif
    take();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    int t;
    longint c4_exp [3];
    rst_n     = 1'b0;
    in_valid  = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0;
    b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0;
    c4_exp[0] = 8; c4_exp[1] = 15; c4_exp[2] = 15;

    repeat (3) @(negedge clk);
    check("rst_in_ready",       in_ready,       0);
    check("rst_out_valid",      out_valid,      0);
    check("rst_out_ones",       out_ones,       0);
    check("rst_out_frame_ones", out_frame_ones, 0);
    check("rst_out_last",       out_last,       0);
`ifdef PARITY_SEG_EN
    check("rst_hex",            hex,            SEG_E);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", in_ready, 1);

    // Build up frame state, then reset in the middle of a scan.
    send(8'hB5, 1'b0);
    expect_word("pre", 5, 1, 5, 1);
    send(8'h3C, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid",      out_valid,      0);
    check("midrst_in_ready",       in_ready,       0);
    check("midrst_out_ones",       out_ones,       0);
    check("midrst_out_odd",        out_odd,        0);
    check("midrst_out_frame_ones", out_frame_ones, 0);
    check("midrst_out_frame_odd",  out_frame_odd,  0);
`ifdef PARITY_SEG_EN
    check("midrst_hex",            hex,            SEG_E);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_in_ready_after", in_ready, 1);

    // Single-word frame, then the frame must clear on the handshake.
    send(8'hB5, 1'b1);
    expect_word("single", 5, 1, 5, 1);
    check("single_clear_frame_ones", out_frame_ones, 0);
    check("single_clear_frame_odd",  out_frame_odd,  0);

    // Three-word frame followed by a fresh frame.
    send(8'hFF, 1'b0); expect_word("f3_w0", 8, 0, 8, 0);
    send(8'h01, 1'b0); expect_word("f3_w1", 1, 1, 9, 1);
    send(8'h80, 1'b1); expect_word("f3_w2", 1, 1, 10, 0);
    send(8'h03, 1'b1); expect_word("f3_next", 2, 0, 2, 0);

    // Edge patterns.
    send(8'h00, 1'b0); expect_word("zero", 0, 0, 0, 0);
    send(8'hFF, 1'b1); expect_word("full", 8, 0, 8, 0);

    // Back-pressure: in_valid held high with changing data while HOLD persists.
    send(8'h0F, 1'b1);
    wait_valid();
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hA0 + 8'(i);
      @(negedge clk);
      if (i == 19) check("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    check("bp_ones", out_ones, 4);
    take();
    repeat (5) @(negedge clk);
    check("bp_no_extra_valid", out_valid, 0);
    check("accept_count", acc_count, n_sent);

    // WIDTH=5: latency and count.
    @(negedge clk);
    t = 0;
    while (!a_in_ready && t < 100) begin @(negedge clk); t++; end
    a_in_valid = 1'b1;
    a_in_data  = 5'h1F;
    @(posedge clk);
    #1 a_in_valid = 1'b0;
    lat = 0;
    while (!a_out_valid && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("w5_latency", lat, 5);
    check("w5_ones",    a_out_ones, 5);
    check("w5_odd",     a_out_odd,  1);
    check("w5_frame",   a_out_frame_ones, 5);

    // CNT_W=4: accumulator saturation, parity from the true sum.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      t = 0;
      while (!b_in_ready && t < 100) begin @(negedge clk); t++; end
      b_in_valid = 1'b1;
      b_in_data  = 8'hFF;
      b_in_last  = (i == 2);
      @(negedge clk);
      b_in_valid = 1'b0;
      t = 0;
      while (!b_out_valid && t < 100) begin @(negedge clk); t++; end
      check("c4_valid",      b_out_valid,      1);
      check("c4_ones",       b_out_ones,       8);
      check("c4_frame_ones", b_out_frame_ones, c4_exp[i]);
      check("c4_frame_odd",  b_out_frame_odd,  0);
    end
    @(negedge clk);
    check("c4_frame_cleared", b_out_frame_ones, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
